// File: rtl/int_to_double_if.sv
// Stream interface for the integer-to-double converter: operand in, result out,
// each direction using a stb/ack handshake.
interface int_to_double_if;
  logic [63:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [63:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  modport master (
    output input_a, input_a_stb, output_z_ack,
    input  input_a_ack, output_z, output_z_stb
  );

  modport slave (
    input  input_a, input_a_stb, output_z_ack,
    output input_a_ack, output_z, output_z_stb
  );
endinterface

// File: rtl/int_to_double.sv
// Multi-cycle converter from a 64-bit signed integer to an IEEE-754 double,
// round to nearest, ties to even. One conversion in flight at a time.
module int_to_double (
  input logic            clk,
  input logic            rst,
  int_to_double_if.slave bus
);

  typedef enum logic [2:0] {GET_A, CONVERT, NORMALISE, ROUND, PACK, PUT_Z} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [63:0] r_a;
  logic [63:0] r_m;
  logic [63:0] r_z;
  logic [63:0] r_out_z;
  logic [52:0] r_mant;
  logic [10:0] r_e;
  logic        r_s;
  logic        r_ack;
  logic        r_stb;

  logic [63:0] w_mag;
  logic        w_round_up;
  logic [53:0] w_mant_inc;

  assign w_mag      = r_a[63] ? (~r_a + 64'd1) : r_a;
  assign w_round_up = r_m[10] && (r_m[9] || (|r_m[8:0]) || r_m[11]);
  assign w_mant_inc = {1'b0, r_m[63:11]} + 54'd1;

  assign bus.input_a_ack  = r_ack;
  assign bus.output_z_stb = r_stb;
  assign bus.output_z     = r_out_z;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= GET_A;
    else      r_state <= w_state_next;
  end

  // NOTE: the default assignment first means every path drives w_state_next, so no latch.
  // Normalisation exits as the top bit is shifted in, so a magnitude needing
  // lz shifts spends exactly lz cycles in NORMALISE (none if already normalised).
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      GET_A:     if (bus.input_a_stb && r_ack) w_state_next = CONVERT;
      CONVERT: begin
        if (r_a == 64'd0)   w_state_next = PUT_Z;
        else if (w_mag[63]) w_state_next = ROUND;
        else                w_state_next = NORMALISE;
      end
      NORMALISE: if (r_m[62]) w_state_next = ROUND;
      ROUND:     w_state_next = PACK;
      PACK:      w_state_next = PUT_Z;
      PUT_Z:     if (r_stb && bus.output_z_ack) w_state_next = GET_A;
      default:   w_state_next = GET_A;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a     <= 64'd0;
      r_m     <= 64'd0;
      r_z     <= 64'd0;
      r_out_z <= 64'd0;
      r_mant  <= 53'd0;
      r_e     <= 11'd0;
      r_s     <= 1'b0;
      r_ack   <= 1'b0;
      r_stb   <= 1'b0;
    end else begin
      unique case (r_state)
        GET_A: begin
          r_ack <= 1'b1;
          if (bus.input_a_stb && r_ack) begin
            r_a   <= bus.input_a;
            r_ack <= 1'b0;
          end
        end
        CONVERT: begin
          if (r_a == 64'd0) begin
            r_z <= 64'd0;
          end else begin
            r_s <= r_a[63];
            r_m <= w_mag;
            r_e <= 11'd63;
          end
        end
        NORMALISE: begin
          if (!r_m[63]) begin
            r_m <= r_m << 1;
            r_e <= r_e - 11'd1;
          end
        end
        ROUND: begin
          if (!w_round_up) begin
            r_mant <= r_m[63:11];
          end else if (w_mant_inc[53]) begin
            r_mant <= w_mant_inc[53:1];
            r_e    <= r_e + 11'd1;
          end else begin
            r_mant <= w_mant_inc[52:0];
          end
        end
        PACK: r_z <= {r_s, r_e + 11'd1023, r_mant[51:0]};
        PUT_Z: begin
          if (!r_stb) begin
            r_stb   <= 1'b1;
            r_out_z <= r_z;
          end else if (bus.output_z_ack) begin
            r_stb <= 1'b0;
          end
        end
        default: r_ack <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_double.sv
// Randomised bench for int_to_double against an arithmetic rounding model,
// plus directed corners, back-pressure and mid-flight reset.
module tb_int_to_double;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int_to_double_if bus ();

  int_to_double dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  function automatic int msb_pos(input logic [63:0] mag);
    int p = 63;
    while (p > 0 && !mag[p]) p--;
    return p;
  endfunction

  // Reference: take the magnitude, keep the top 53 significant bits and round
  // the discarded remainder against exactly one half ulp.
  function automatic logic [63:0] ref_double(input logic [63:0] a);
    logic        s;
    logic [63:0] mag, keep, rem, half;
    int          p, sh;
    if (a == 64'd0) return 64'd0;
    s   = a[63];
    mag = s ? -a : a;
    p   = msb_pos(mag);
    if (p <= 52) begin
      keep = mag << (52 - p);
    end else begin
      sh   = p - 52;
      keep = mag >> sh;
      rem  = mag & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && keep[0])) keep = keep + 64'd1;
      if (keep[53]) begin
        keep = keep >> 1;
        p    = p + 1;
      end
    end
    return {s, 11'(p + 1023), keep[51:0]};
  endfunction

  function automatic int ref_lat(input logic [63:0] a);
    logic [63:0] mag;
    if (a == 64'd0) return 2;
    mag = a[63] ? -a : a;
    return 4 + (63 - msb_pos(mag));
  endfunction

  task automatic wait_capture(input logic [63:0] a);
    int cyc = 0;
    @(negedge clk);
    bus.input_a     = a;
    bus.input_a_stb = 1'b1;
    while (!bus.input_a_ack && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("capture_ack", {63'd0, bus.input_a_ack}, 64'd1);
    @(posedge clk);
  endtask

  task automatic run_one(input logic [63:0] a, input logic [63:0] exp_z,
                         input int hold, input bit keep_stb);
    int lat = 0;
    wait_capture(a);
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1 && !keep_stb) bus.input_a_stb = 1'b0;
    end while (!bus.output_z_stb && lat < 100);
    check($sformatf("lat a=%h", a), 64'(lat), 64'(ref_lat(a)));
    check($sformatf("z a=%h", a), bus.output_z, exp_z);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_z", bus.output_z, exp_z);
      check("hold_stb", {63'd0, bus.output_z_stb}, 64'd1);
      check("hold_in_ack", {63'd0, bus.input_a_ack}, 64'd0);
    end
    bus.output_z_ack = 1'b1;
    @(negedge clk);
    bus.output_z_ack = 1'b0;
    check("stb_drop", {63'd0, bus.output_z_stb}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    logic [52:0] m53;
    int          k, stb_seen;

    bus.input_a      = 64'd0;
    bus.input_a_stb  = 1'b0;
    bus.output_z_ack = 1'b0;
    #1;
    check("rst_stb", {63'd0, bus.output_z_stb}, 64'd0);
    check("rst_ack", {63'd0, bus.input_a_ack}, 64'd0);
    check("rst_z", bus.output_z, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("ack_rise", {63'd0, bus.input_a_ack}, 64'd1);

    run_one(64'h0, 64'h0000000000000000, 0, 0);
    run_one(64'h1, 64'h3FF0000000000000, 0, 0);
    run_one(64'hFFFFFFFFFFFFFFFF, 64'hBFF0000000000000, 0, 0);
    run_one(64'h8000000000000000, 64'hC3E0000000000000, 0, 0);
    run_one(64'h7FFFFFFFFFFFFFFF, 64'h43E0000000000000, 0, 0);
    run_one(64'h0020000000000001, 64'h4340000000000000, 0, 0);
    run_one(64'h0020000000000003, 64'h4340000000000002, 0, 0);

    // Back-pressure with the operand strobe held high throughout.
    run_one(64'd123456789, ref_double(64'd123456789), 20, 1);
    run_one(-64'd987654321987, ref_double(-64'd987654321987), 5, 1);
    bus.input_a_stb = 1'b0;

    for (int i = 0; i < 40; i++) begin
      a = {$urandom(), $urandom()};
      a = a >> $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) a = -a;
      run_one(a, ref_double(a), $urandom_range(0, 2), 0);
    end

    for (int i = 0; i < 12; i++) begin
      m53 = {1'b1, 20'($urandom()), $urandom()};
      k   = $urandom_range(1, 11);
      a   = (64'(m53) << k) | (64'd1 << (k - 1));
      if ($urandom_range(0, 1) == 1) a = -a;
      run_one(a, ref_double(a), 0, 0);
    end

    // Reset while a=1 is normalising.
    wait_capture(64'd1);
    @(negedge clk);
    bus.input_a_stb = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_stb", {63'd0, bus.output_z_stb}, 64'd0);
    check("midrst_ack", {63'd0, bus.input_a_ack}, 64'd0);
    check("midrst_z", bus.output_z, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    stb_seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.output_z_stb) stb_seen++;
    end
    check("no_result_after_rst", 64'(stb_seen), 64'd0);
    run_one(64'd1000, 64'h408F400000000000, 0, 0);

    // Reset while the result strobe is up.
    wait_capture(64'd5);
    @(negedge clk);
    bus.input_a_stb = 1'b0;
    k = 0;
    while (!bus.output_z_stb && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("putz_stb_up", {63'd0, bus.output_z_stb}, 64'd1);
    #2 rst = 1'b0;
    #1;
    check("putz_rst_stb", {63'd0, bus.output_z_stb}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run_one(-64'd2, 64'hC000000000000000, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
